// File: rtl/alu_pkg.sv
// Shared ALU opcode type and arbiter sizing helpers.
package alu_pkg;

    localparam int unsigned ARB_MAX_REQ = 8;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_opcode_t;

    // Requester ID width: ceil(log2(n)), never below one bit.
    function automatic int unsigned arb_id_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/alu.sv
// Shared combinational 32-bit ALU; unknown opcodes yield zero.
module alu
    import alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_opcode_t op,
    output logic [31:0] y_c
);

    always_comb begin
        y_c = '0;
        case (op)
            ALU_ADD:  y_c = a + b;
            ALU_SUB:  y_c = a - b;
            ALU_AND:  y_c = a & b;
            ALU_OR:   y_c = a | b;
            ALU_XOR:  y_c = a ^ b;
            ALU_SLL:  y_c = a << b[4:0];
            ALU_SRL:  y_c = a >> b[4:0];
            ALU_SRA:  y_c = 32'($signed(a) >>> b[4:0]);
            ALU_SLT:  y_c = 32'($signed(a) < $signed(b));
            ALU_SLTU: y_c = 32'(a < b);
            default:  y_c = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr, with wrap.
module rr_arbiter #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = ptr;
        for (int unsigned off = 0; off < N; off++) begin
            if (en && !found && req[cand]) begin
                grant[cand] = 1'b1;
                idx         = cand;
                found       = 1'b1;
            end
            cand = (cand == IW'(N - 1)) ? '0 : cand + IW'(1);
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin sharing of one ALU between NUM_REQ requesters with a one-entry result stage.
// Optional per-requester saturating grant counters under ALU_ARB_PERF_EN.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = arb_id_w(NUM_REQ)
`ifdef ALU_ARB_PERF_EN
    ,
    parameter int unsigned CNT_W   = 16
`endif
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic [NUM_REQ*32-1:0]     i_req_op1,
    input  logic [NUM_REQ*32-1:0]     i_req_op2,
    input  alu_opcode_t [NUM_REQ-1:0] i_req_alu_op,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [ID_W-1:0]           o_rsp_id,
    output logic [31:0]               o_rsp_result
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0]  o_grant_cnt
`endif
);

    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    gnt_idx;
    logic [NUM_REQ-1:0] grant;
    logic               can_accept;
    logic               xfer;
    logic [31:0]        op1_arr [NUM_REQ];
    logic [31:0]        op2_arr [NUM_REQ];
    logic [31:0]        alu_y;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign op1_arr[k] = i_req_op1[32*k +: 32];
        assign op2_arr[k] = i_req_op2[32*k +: 32];
    end

    // Result slot frees up either because it is empty or is draining this cycle.
    assign can_accept  = !o_rsp_valid || i_rsp_ready;
    assign o_req_ready = grant;
    assign xfer        = |grant;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_arb (
        .req   (i_req_valid),
        .ptr   (ptr_q),
        .en    (can_accept && i_rst_n),
        .grant (grant),
        .idx   (gnt_idx)
    );

    alu u_alu (
        .a   (op1_arr[gnt_idx]),
        .b   (op2_arr[gnt_idx]),
        .op  (i_req_alu_op[gnt_idx]),
        .y_c (alu_y)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ptr_q        <= '0;
            o_rsp_valid  <= 1'b0;
            o_rsp_id     <= '0;
            o_rsp_result <= '0;
        end else if (xfer) begin
            ptr_q        <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
            o_rsp_valid  <= 1'b1;
            o_rsp_id     <= gnt_idx;
            o_rsp_result <= alu_y;
        end else if (i_rsp_ready) begin
            o_rsp_valid  <= 1'b0;
        end
    end

`ifdef ALU_ARB_PERF_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_grant_cnt <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (grant[k] && (o_grant_cnt[k*CNT_W +: CNT_W] != '1))
                    o_grant_cnt[k*CNT_W +: CNT_W] <= o_grant_cnt[k*CNT_W +: CNT_W] + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares one combinational `alu` instance between NUM_REQ requesters, e.g. the execute stage and the address-generation/branch-target unit.
- Round-robin arbitration with a valid/ready request handshake on each requester.
- One-entry registered result stage with valid/ready backpressure, tagged with the requester ID.
- Sits between issue logic and writeback/AGU consumers; one ALU operation completes per cycle at full throughput.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ) (min 1), width of the requester ID on the result channel.
- CNT_W, 16, width of the per-requester grant counters (optional feature only).

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_req_valid  in  NUM_REQ  per-requester request valid.
- o_req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- i_req_op1  in  NUM_REQ*32  operand 1; requester k at [32k+31:32k].
- i_req_op2  in  NUM_REQ*32  operand 2, same packing.
- i_req_alu_op  in  NUM_REQ x alu_opcode_t  packed opcode array.
- o_rsp_valid  out  1  result register holds a result.
- i_rsp_ready  in  1  consumer accepts the result.
- o_rsp_id  out  ID_W  requester that issued the result.
- o_rsp_result  out  32  ALU result.
- o_grant_cnt  out  NUM_REQ*CNT_W  saturating grant counters; present only with ALU_ARB_PERF_EN.

Behaviour:
- Reset (i_rst_n=0 sampled at a clock edge):
  - o_rsp_valid=0, o_rsp_id=0, o_rsp_result=0.
  - RR pointer=0.
  - Counters=0.
- o_req_ready is combinational and zero during reset.
- can_accept = !o_rsp_valid || i_rsp_ready.
- Grant:
  - When can_accept, grant the first requester with valid set, scanning from the RR pointer upward with wrap modulo NUM_REQ.
  - o_req_ready has exactly that bit set.
  - All ready bits are 0 when !can_accept or no requester is valid.
- Transfer: a request transfers when i_req_valid[k] && o_req_ready[k].
- Issue to the ALU:
  - The granted requester's op1/op2/alu_op are muxed to the ALU.
  - On transfer, o_rsp_result<=ALU result, o_rsp_id<=k, o_rsp_valid<=1.
- RR pointer: on transfer, pointer<=(k+1) mod NUM_REQ; otherwise it holds.
- Latency and throughput:
  - Result is visible the cycle after acceptance (1-cycle latency).
  - Back-to-back issue at 1/cycle while i_rsp_ready=1.
- Drain: o_rsp_valid && i_rsp_ready with no new transfer -> o_rsp_valid<=0.
- Simultaneous drain and transfer: the register is overwritten with the new result and o_rsp_valid stays 1; no bubble.
- Backpressure:
  - o_rsp_valid && !i_rsp_ready -> all ready bits 0.
  - Result, ID and valid hold stable.
- Requester rule: operands and opcode must stay stable while valid && !ready. The arbiter does not latch them before the grant.
- Grant-to-ready path is combinational (valid -> ready); no combinational path from the ready outputs back into the arbitration.
- Undefined or default opcodes return 0, as the ALU already does; no error flag.
- Reset mid-operation: a pending result is discarded, o_rsp_valid drops the cycle after reset is sampled, and the pointer returns to 0.
- Single requester: with only one requester valid, it is granted every cycle that can_accept is true.

Optional Feature:
- Macro: ALU_ARB_PERF_EN.
- Defined:
  - Adds o_grant_cnt: one CNT_W counter per requester.
  - Counter k increments on each transfer of requester k and saturates at all-ones; no wrap.
  - Cleared only by reset.
- Undefined:
  - Port and counters are absent.
  - Arbitration and datapath timing are identical to the defined case.

Decomposition:
- alu_pkg:
  - alu_opcode_t, the opcode type already shared with `alu`.
  - ARB_MAX_REQ=8 and a localparam helper for ID width.
- Sub-module rr_arbiter:
  - Inputs: request vector, pointer, enable.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational; reusable for future shared units (multiplier, LSU port).
- alu_share_arb holds the pointer, result register, counters and the `alu` instance.

Test Plan:
- Single request, i_rsp_ready=1: req0 ADD op1=5, op2=7 -> ready[0]=1 same cycle; next cycle o_rsp_valid=1, id=0, result=12.
- Contention, NUM_REQ=2, both valid continuously: req0 SUB 10-3, req1 SLT -1<1 -> grants alternate 0,1,0,1; results 7 and 1 with matching IDs on consecutive cycles, no bubbles.
- Backpressure:
  - Hold i_rsp_ready=0 for 3 cycles with a result pending (SRA 0x80000000 by 4 = 0xF8000000).
  - Expect ready bits=0 and the output stable.
  - On release, drain and accept the next request in the same cycle.
- Wrap: NUM_REQ=3, pointer at 2, only req0 and req2 valid -> req2 granted, then req0 (pointer wraps to 0).
- Reset mid-flight: pending result valid, i_rst_n=0 one cycle -> o_rsp_valid=0, result=0, pointer=0; next grant goes to req0 when all are valid.
- With ALU_ARB_PERF_EN and CNT_W=2:
  - 5 grants to req1 -> o_grant_cnt[1]=3 (saturated), o_grant_cnt[0]=0.
  - Repeat the build without the macro; bench compiles with no o_grant_cnt and the same grant sequence.
